// File: rtl/serial_pattern_tx_pkg.sv
// Shared state codes and counter sizing for serial_pattern_tx.
// TX_PARITY_EN in the top selects whether the PARITY code is reachable.
package serial_pattern_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_PARITY = 2'b10,
        ST_GAP    = 2'b11
    } tx_state_e;

    // Counter must hold the value n itself; never narrower than one bit.
    function automatic int tx_cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_shift.sv
// WIDTH-bit load/shift register presenting its MSB; shifts left, zero-filling.
// Latency: load/shift visible one edge later; no backpressure, enables only.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_sreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sreg <= '0;
        end else if (i_load) begin
            r_sreg <= i_data;
        end else if (i_shift) begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_sreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serialises a WIDTH-bit word MSB-first on w, optional even parity (TX_PARITY_EN), then GAP idle zeros.
// Latency: first bit on w the cycle after accept; ready only in IDLE, so valid waits out a whole frame.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             w,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = tx_cnt_width(WIDTH);
    localparam int GAP_W = tx_cnt_width(GAP);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_pattern_tx: WIDTH must be at least 2");
        end
        if (GAP < 1) begin : g_bad_gap
            $error("serial_pattern_tx: GAP must be at least 1");
        end
    endgenerate

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic             r_w;
    logic             w_w_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;
    logic             w_load;
    logic             w_shift;
    logic             w_piso_msb;
`ifdef TX_PARITY_EN
    logic             r_par;
`endif

    // The MSB goes straight to w on accept, so the shifter only holds the bits still to send.
    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  ({data[WIDTH-2:0], 1'b0}),
        .o_msb   (w_piso_msb)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_w_nxt       = 1'b0;
        w_done_nxt    = 1'b0;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_load        = 1'b0;
        w_shift       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid) begin
                    w_load        = 1'b1;
                    w_w_nxt       = data[WIDTH-1];
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bit_cnt != LAST_BIT) begin
                    w_w_nxt       = w_piso_msb;
                    w_shift       = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end else begin
`ifdef TX_PARITY_EN
                    w_w_nxt       = r_par;
                    w_state_nxt   = ST_PARITY;
`else
                    w_done_nxt    = 1'b1;
                    w_gap_cnt_nxt = GAP_W'(1);
                    w_state_nxt   = ST_GAP;
`endif
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                w_done_nxt    = 1'b1;
                w_gap_cnt_nxt = GAP_W'(1);
                w_state_nxt   = ST_GAP;
            end
`endif
            ST_GAP: begin
                if (r_gap_cnt == LAST_GAP) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_w       <= 1'b0;
            r_done    <= 1'b0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_w       <= w_w_nxt;
            r_done    <= w_done_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

`ifdef TX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^data;
        end
    end
`endif

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state != ST_IDLE);
    assign w     = r_w;
    assign done  = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Randomised and directed bench for serial_pattern_tx against a frame-queue reference model.
module tb_serial_pattern_tx;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
`ifdef TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic w;
        logic busy;
        logic done;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             w;
    logic             busy;
    logic             done;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    exp_t q[$];
    logic last_w;
    logic last_ready;

    serial_pattern_tx #(
        .WIDTH (WIDTH),
        .GAP   (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .data  (data),
        .ready (ready),
        .w     (w),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Whole-frame expectation: data bits MSB first, optional parity, GAP zeros with done on the first.
    task automatic push_frame(input logic [WIDTH-1:0] d);
        exp_t e;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            e = '{w: d[i], busy: 1'b1, done: 1'b0};
            q.push_back(e);
        end
        if (PAR == 1) begin
            e = '{w: ^d, busy: 1'b1, done: 1'b0};
            q.push_back(e);
        end
        for (int g = 0; g < GAP; g++) begin
            e = '{w: 1'b0, busy: 1'b1, done: (g == 0)};
            q.push_back(e);
        end
    endtask

    // Called just after a falling edge: check this cycle's outputs, then drive inputs for the next rising edge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
        exp_t e;
        logic er;
        if (q.size() > 0) begin
            e  = q.pop_front();
            er = 1'b0;
        end else begin
            e  = '0;
            er = 1'b1;
        end
        check_eq("w", {31'd0, w}, {31'd0, e.w});
        check_eq("busy", {31'd0, busy}, {31'd0, e.busy});
        check_eq("done", {31'd0, done}, {31'd0, e.done});
        check_eq("ready", {31'd0, ready}, {31'd0, er});
        last_w     = w;
        last_ready = ready;
        valid = v;
        data  = d;
        if (er && v) push_frame(d);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle(1'b0, WIDTH'($urandom));
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_w", {31'd0, w}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        q.delete();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send_and_capture(input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] cap);
        cycle(1'b1, d);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            cycle(1'b0, WIDTH'($urandom));
            cap[i] = last_w;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] cap;
        int k;
        reset = 1'b1;
        valid = 1'b0;
        data  = '0;
        #3;
        check_eq("init_w", {31'd0, w}, 32'd0);
        check_eq("init_ready", {31'd0, ready}, 32'd1);
        check_eq("init_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) cycle(1'b0, '0);

        send_and_capture(8'hB4, cap);
        check_eq("b4_bits", {24'd0, cap}, 32'hB4);
        drain();
        cycle(1'b0, '0);

`ifdef TX_PARITY_EN
        send_and_capture(8'h07, cap);
        check_eq("h07_bits", {24'd0, cap}, 32'h07);
        cycle(1'b0, '0);
        check_eq("h07_parity", {31'd0, last_w}, 32'd1);
        drain();
        send_and_capture(8'hB4, cap);
        cycle(1'b0, '0);
        check_eq("b4_parity", {31'd0, last_w}, 32'd0);
        drain();
        cycle(1'b0, '0);
`endif

        // valid held high: changing data while busy must not reach w
        cycle(1'b1, 8'hFF);
        k = 1;
        while (k <= 30) begin
            cycle(1'b1, ready ? 8'h00 : WIDTH'($urandom));
            if (last_ready) break;
            k++;
        end
        check_eq("b2b_spacing", k, WIDTH + PAR + GAP + 1);
        drain();

        // reset part way through a frame, then a clean frame
        cycle(1'b1, 8'hAA);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0);
        pulse_reset();
        cycle(1'b0, '0);
        send_and_capture(8'h81, cap);
        check_eq("h81_bits", {24'd0, cap}, 32'h81);
        drain();

        for (int i = 0; i < 30; i++) cycle(1'b0, WIDTH'($urandom));

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), WIDTH'($urandom));
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end
        drain();
        cycle(1'b0, '0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
